// File: rtl/mem_sram_ctrl_if.sv
// MEM-stage request bus plus the external 16-bit asynchronous SRAM pins.
// The master side is the pipeline together with the SRAM device.
interface mem_sram_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              rd_en;
    logic              wr_en;
    logic [31:0]       address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              ready;
    logic              freeze;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_in;
    logic              sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases (low half
// first) and freezes the pipeline until the access completes.
module mem_sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input logic          clk,
    input logic          rst,
    mem_sram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        counter;
    logic              is_store;
    logic [ADDR_W-2:0] word_q;
    logic [15:0]       data_hi_q;
    logic              request;
    logic              phase_last;
    logic              ready;
    logic [31:0]       req_offset;
    logic              unused_offset_bits;

    assign request    = bus.rd_en | bus.wr_en;
    assign phase_last = (counter == LAST_COUNT);
    // Modulo-2^32 offset; only the bits that land in a halfword address are kept.
    assign req_offset = bus.address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{req_offset[31:ADDR_W+1], req_offset[1:0]};

    assign bus.ready  = ready;
    assign bus.freeze = ~ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = ~request;
                if (request) state_next = LO;
            end
            LO:      if (phase_last) state_next = HI;
            HI:      if (phase_last) state_next = DONE;
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // SRAM pins are registered and loaded on entry to each phase so that
    // address, data and strobe stay stable for the whole phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter         <= '0;
            is_store        <= 1'b0;
            word_q          <= '0;
            data_hi_q       <= '0;
            bus.read_data   <= '0;
            bus.sram_addr   <= '0;
            bus.sram_dq_out <= '0;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_we_n   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    counter <= '0;
                    if (request) begin
                        is_store        <= bus.wr_en;
                        word_q          <= req_offset[ADDR_W:2];
                        data_hi_q       <= bus.write_data[31:16];
                        bus.sram_addr   <= {req_offset[ADDR_W:2], 1'b0};
                        bus.sram_dq_out <= bus.write_data[15:0];
                        bus.sram_dq_oe  <= bus.wr_en;
                        bus.sram_we_n   <= ~bus.wr_en;
                    end
                end
                LO: begin
                    if (phase_last) begin
                        counter         <= '0;
                        bus.sram_addr   <= {word_q, 1'b1};
                        bus.sram_dq_out <= data_hi_q;
                        if (!is_store) bus.read_data[15:0] <= bus.sram_dq_in;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                HI: begin
                    if (phase_last) begin
                        counter        <= '0;
                        bus.sram_dq_oe <= 1'b0;
                        bus.sram_we_n  <= 1'b1;
                        if (!is_store) bus.read_data[31:16] <= bus.sram_dq_in;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                default: counter <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Randomized bench for mem_sram_ctrl at WAIT_CYCLES 1 and 2, checked against a
// word-level memory model; each DUT drives its own behavioural SRAM.
module tb_mem_sram_ctrl;
    localparam int AW   = 18;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    int          sel = 2;   // selected DUT, equal to its WAIT_CYCLES

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_sram_ctrl_if #(.ADDR_W(AW)) bus_w1 ();
    mem_sram_ctrl_if #(.ADDR_W(AW)) bus_w2 ();

    mem_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut_w1 (
        .clk(clk), .rst(rst), .bus(bus_w1)
    );
    mem_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut_w2 (
        .clk(clk), .rst(rst), .bus(bus_w2)
    );

    assign bus_w1.rd_en      = rd_en && (sel == 1);
    assign bus_w1.wr_en      = wr_en && (sel == 1);
    assign bus_w1.address    = address;
    assign bus_w1.write_data = write_data;
    assign bus_w2.rd_en      = rd_en && (sel == 2);
    assign bus_w2.wr_en      = wr_en && (sel == 2);
    assign bus_w2.address    = address;
    assign bus_w2.write_data = write_data;

    // Asynchronous SRAM devices: combinational read, write while we_n low and bus driven.
    logic [15:0] sram_w1 [0:2**AW-1] = '{default: 16'h0};
    logic [15:0] sram_w2 [0:2**AW-1] = '{default: 16'h0};
    assign bus_w1.sram_dq_in = sram_w1[bus_w1.sram_addr];
    assign bus_w2.sram_dq_in = sram_w2[bus_w2.sram_addr];
    always @(negedge clk) begin
        if (!bus_w1.sram_we_n && bus_w1.sram_dq_oe) sram_w1[bus_w1.sram_addr] <= bus_w1.sram_dq_out;
        if (!bus_w2.sram_we_n && bus_w2.sram_dq_oe) sram_w2[bus_w2.sram_addr] <= bus_w2.sram_dq_out;
    end

    logic          ready_o, freeze_o, we_n_o, oe_o;
    logic [AW-1:0] addr_o;
    logic [15:0]   dq_o;
    logic [31:0]   rd_o;
    always_comb begin
        if (sel == 1) begin
            ready_o = bus_w1.ready;     freeze_o = bus_w1.freeze;
            we_n_o  = bus_w1.sram_we_n; oe_o     = bus_w1.sram_dq_oe;
            addr_o  = bus_w1.sram_addr; dq_o     = bus_w1.sram_dq_out;
            rd_o    = bus_w1.read_data;
        end else begin
            ready_o = bus_w2.ready;     freeze_o = bus_w2.freeze;
            we_n_o  = bus_w2.sram_we_n; oe_o     = bus_w2.sram_dq_oe;
            addr_o  = bus_w2.sram_addr; dq_o     = bus_w2.sram_dq_out;
            rd_o    = bus_w2.read_data;
        end
    end

    // Reference model: 32-bit words keyed by DUT and SRAM word index.
    logic [31:0]   ref_mem [int unsigned];
    logic [31:0]   exp_rd  [1:2];
    logic [AW-1:0] last_hi [1:2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t, W=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    task automatic access(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit drop);
        int            w;
        logic [31:0]   word;
        logic [AW-1:0] lo, hi;
        int unsigned   key;
        w    = sel;
        word = (addr - BASE) / 4;
        lo   = AW'(word * 2);
        hi   = AW'(word * 2 + 1);
        key  = 32'(sel) * 32'h0100_0000 + (word % (32'd1 << (AW - 1)));
        if (do_wr) ref_mem[key] = data;
        else       exp_rd[sel] = ref_mem.exists(key) ? ref_mem[key] : 32'h0;

        @(posedge clk); #1;
        rd_en = do_rd; wr_en = do_wr; address = addr; write_data = data;
        @(negedge clk);
        check("req_ready", ready_o, 0);
        check("req_freeze", freeze_o, 1);
        for (int c = 1; c <= 2 * w; c++) begin
            @(posedge clk); #1;
            if (drop && c == 1) begin
                rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
            end
            @(negedge clk);
            check($sformatf("ph%0d_ready", c), ready_o, 0);
            check($sformatf("ph%0d_addr", c), addr_o, (c <= w) ? lo : hi);
            check($sformatf("ph%0d_we_n", c), we_n_o, !do_wr);
            check($sformatf("ph%0d_oe", c), oe_o, do_wr);
            if (do_wr) check($sformatf("ph%0d_dq", c), dq_o, (c <= w) ? data[15:0] : data[31:16]);
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("done_ready", ready_o, 1);
        check("done_freeze", freeze_o, 0);
        check("done_we_n", we_n_o, 1);
        check("done_read_data", rd_o, exp_rd[sel]);
        last_hi[sel] = hi;
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom;
        @(negedge clk);
        check("idle_ready", ready_o, 1);
        check("idle_we_n", we_n_o, 1);
        check("idle_oe", oe_o, 0);
        check("idle_addr", addr_o, last_hi[sel]);
        check("idle_read_data", rd_o, exp_rd[sel]);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, ready_o, 1);
        check({tag, "_freeze"}, freeze_o, 0);
        check({tag, "_we_n"}, we_n_o, 1);
        check({tag, "_oe"}, oe_o, 0);
        check({tag, "_addr"}, addr_o, 0);
        check({tag, "_dq"}, dq_o, 0);
        check({tag, "_read_data"}, rd_o, 0);
        exp_rd[1] = '0; exp_rd[2] = '0; last_hi[1] = '0; last_hi[2] = '0;
    endtask

    task automatic reset_mid_load(input logic [31:0] addr);
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b0; address = addr;
        repeat (sel + 1) @(posedge clk);
        #2;
        check("hi_before_reset", ready_o, 0);
        rst = 1'b1; rd_en = 1'b0;
        #1;
        reset_checks("mid_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #3 rst = 1'b1;
        #1 reset_checks("por");
        @(negedge clk);
        rst = 1'b0;

        sel = 2;
        idle_check();
        access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        check("tp_load_w2", rd_o, 32'hDEAD_BEEF);
        access(1'b1, 1'b1, 32'd1040, 32'h1234_5678, 1'b0);
        check("tp_prio_keep", rd_o, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'd1048, 32'hCAFE_F00D, 1'b1);
        access(1'b1, 1'b0, 32'd1048, 32'h0, 1'b1);
        check("tp_drop_load", rd_o, 32'hCAFE_F00D);

        sel = 1;
        access(1'b0, 1'b1, 32'd1024, 32'hA5A5_5A5A, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        check("tp_b2b_w1", rd_o, 32'hA5A5_5A5A);
        reset_mid_load(32'd1024);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);

        sel = 2;
        reset_mid_load(32'd1032);
        idle_check();
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        check("tp_after_rst", rd_o, 32'hDEAD_BEEF);

        for (int w = 1; w <= 2; w++) begin
            sel = w;
            for (int n = 0; n < 60; n++) begin
                int          op;
                logic [31:0] a;
                op = $urandom_range(0, 2);
                if ($urandom_range(0, 7) == 0) a = $urandom;
                else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                access(op != 1, op != 0, a, $urandom, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle_check();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
Sequences data-memory accesses of the MEM stage onto an external 16-bit asynchronous SRAM. Each 32-bit load or store becomes two 16-bit SRAM phases, low half first. While an access is in flight it drives freeze, which stalls all pipeline stage registers upstream of and including the MEM/WB register. It sits between the MEM-stage ALU address/store data and the MEM/WB register's data-memory input.

Parameters:
ADDR_W, 18, SRAM halfword address width.
WAIT_CYCLES, 2, clock cycles each SRAM phase is held; legal range 1..15.
BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
rd_en  in  1  load request from MEM stage.
wr_en  in  1  store request from MEM stage.
address  in  32  byte address (ALU result).
write_data  in  32  store data.
read_data  out  32  registered load result.
ready  out  1  access complete / controller idle.
freeze  out  1  equals NOT ready; pipeline hold.
sram_addr  out  ADDR_W  SRAM halfword address.
sram_dq_out  out  16  SRAM write data.
sram_dq_oe  out  1  tristate enable for sram_dq_out.
sram_dq_in  in  16  SRAM read data.
sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, counter = 0, read_data = 0.
  - sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
- States: IDLE, LO, HI, DONE.
- ready is combinational:
  - 1 in IDLE with no request, and in DONE.
  - 0 in IDLE with rd_en or wr_en high, and in LO and HI.
- Request acceptance in IDLE:
  - On rd_en|wr_en, latch the operation, address and write_data; go to LO with counter = 0.
  - wr_en has priority if both are high (store).
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, 32-bit modulo arithmetic, no range check.
  - LO drives sram_addr = {word, 1'b0}; HI drives {word, 1'b1}; both truncated to ADDR_W.
- LO and HI phases:
  - Each lasts exactly WAIT_CYCLES cycles; counter increments per cycle.
  - On the final cycle the counter clears and the state advances (LO->HI, HI->DONE).
  - sram_addr is stable for the entire phase.
- Store phases:
  - sram_we_n = 0 and sram_dq_oe = 1 for all cycles of LO and HI.
  - sram_dq_out = latched data[15:0] in LO, data[31:16] in HI.
- Load phases:
  - sram_we_n = 1, sram_dq_oe = 0.
  - read_data[15:0] captures sram_dq_in on the last cycle of LO; read_data[31:16] on the last cycle of HI.
- DONE:
  - One cycle, ready = 1, read_data valid; unconditional transition to IDLE.
  - read_data holds until the next load overwrites it; stores never modify it.
- Latency:
  - Request first visible in IDLE at cycle 0; ready is low for cycles 0..2*WAIT_CYCLES.
  - ready is high at cycle 2*WAIT_CYCLES+1 (DONE).
  - Pipeline advances at the end of the DONE cycle.
- Boundary conditions:
  - Request inputs changing or dropping during LO/HI are ignored; the access completes from latched values.
  - No request in IDLE: outputs hold idle values; sram_addr holds its last value.
  - Back-to-back requests: a new request seen in IDLE the cycle after DONE starts a new access. There is no pipelining across accesses.
  - rst asserted mid-access aborts immediately to reset values. A partial store may have reached the SRAM; the partial load value is discarded (read_data = 0).

Test Plan:
- Reset: assert rst mid-cycle -> all outputs at reset values immediately; ready=1, freeze=0, sram_we_n=1.
- Store: WAIT_CYCLES=2, wr_en, address=1032, write_data=0xDEADBEEF:
  - cycles 1-2: sram_addr=4, dq_out=0xBEEF, we_n=0.
  - cycles 3-4: sram_addr=5, dq_out=0xDEAD, we_n=0.
  - ready low cycles 0-4, high cycle 5.
- Load: rd_en, address=1032, SRAM model returns 0xBEEF at addr 4 and 0xDEAD at addr 5 -> read_data=0xDEADBEEF in DONE (cycle 5); freeze=1 for exactly 5 cycles.
- Priority and input drop:
  - rd_en=wr_en=1 -> store performed; read_data unchanged.
  - Deassert wr_en and change address in LO -> access still completes to the original address.
- Back-to-back and WAIT_CYCLES=1:
  - Store then load to address 1024 -> load returns the stored value.
  - Each access shows ready low 3 cycles, DONE on the 4th.
- Reset mid-load during HI -> state IDLE, read_data=0, sram_dq_oe=0; next load completes normally.
